// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA-to-IO command initiator.
package dma_pkg;

  localparam int DEF_SZ      = 8;
  localparam int DEF_WSZ     = 8;
  localparam int DEF_TIMEOUT = 64;

  // Number of cycles rx_interrupt is held high to carry one command.
  localparam int CMD_CYCLES  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_RANGE,
    S_CMD_DEST,
    S_XFER,
    S_DONE
  } state_t;

  // True in the states where the initiator owns the data bus.
  function automatic logic is_cmd(input state_t s);
    return (s == S_CMD_RANGE) || (s == S_CMD_DEST);
  endfunction

endpackage

// File: rtl/dma_beat_mon.sv
// Watches the IO device's memory writes during a transfer: counts write
// beats, counts idle cycles since the last beat, and remembers whether the
// device raised its done flag.
module dma_beat_mon
  import dma_pkg::*;
#(
  parameter int WSZ     = DEF_WSZ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           enable,
  input  logic           w_notr,
  input  logic           io_done,
  output logic [WSZ-1:0] beats,
  output logic           timed_out,
  output logic           done_seen
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_q;
  logic          done_q;

  // Beat / idle counters and sticky done flag, live only while enabled.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats  <= '0;
      idle_q <= '0;
      done_q <= 1'b0;
    end else if (clear) begin
      beats  <= '0;
      idle_q <= '0;
      done_q <= 1'b0;
    end else if (enable) begin
      if (w_notr) begin
        beats  <= beats + 1'b1;
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
      if (io_done) done_q <= 1'b1;
    end
  end

  // Fires on the edge where the idle count would reach TIMEOUT, so the
  // transfer aborts after exactly TIMEOUT beat-less cycles.
  assign timed_out = enable && !w_notr && (idle_q == IDLE_LAST);

  // The current cycle's flag counts too, so a device that raises done
  // together with (or just after) its last beat is not reported as missing.
  assign done_seen = done_q || (enable && io_done);

endmodule

// File: rtl/dma_io_cmd.sv
// Initiator side of the DMA-to-IO command protocol: accepts a request,
// issues the two-cycle rx_interrupt command on the shared bus, releases the
// bus, watches the device's writes and reports completion or error.
module dma_io_cmd
  import dma_pkg::*;
#(
  parameter int SZ      = DEF_SZ,
  parameter int WSZ     = DEF_WSZ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [SZ-1:0]  req_io_addr,
  input  logic [WSZ-1:0] req_len,
  input  logic [SZ-1:0]  req_mem_addr,
  input  logic           req_w_notr,
  output logic           io_irq,
  input  logic           io_done,
  inout  wire  [SZ-1:0]  addr,
  inout  wire  [WSZ-1:0] data,
  input  logic           w_notr,
  output logic           cmp_valid,
  output logic           cmp_err,
  output logic [WSZ-1:0] cmp_beats,
  output logic           busy
);

  state_t         state;
  logic [SZ-1:0]  io_addr_q;
  logic [WSZ-1:0] len_q;
  logic [SZ-1:0]  mem_addr_q;
  logic           w_notr_q;

  logic [WSZ-1:0] beats;
  logic           timed_out;
  logic           done_seen;

  logic [SZ-1:0]  addr_drv;
  logic [WSZ-1:0] data_drv;
  logic           data_oe;

  dma_beat_mon #(
    .WSZ     (WSZ),
    .TIMEOUT (TIMEOUT)
  ) u_beat_mon (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == S_IDLE),
    .enable    (state == S_XFER),
    .w_notr    (w_notr),
    .io_done   (io_done),
    .beats     (beats),
    .timed_out (timed_out),
    .done_seen (done_seen)
  );

  // Command sequencer with registered irq and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      io_addr_q  <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      w_notr_q   <= 1'b0;
      io_irq     <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_err    <= 1'b0;
      cmp_beats  <= '0;
    end else begin
      // Completion fields are only meaningful in DONE; zero them elsewhere.
      cmp_valid <= 1'b0;
      cmp_err   <= 1'b0;
      cmp_beats <= '0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            io_addr_q  <= req_io_addr;
            len_q      <= req_len;
            mem_addr_q <= req_mem_addr;
            w_notr_q   <= req_w_notr;
            io_irq     <= 1'b1;
            state      <= S_CMD_RANGE;
          end
        end
        S_CMD_RANGE: state <= S_CMD_DEST;
        S_CMD_DEST: begin
          io_irq <= 1'b0;
          state  <= S_XFER;
        end
        S_XFER: begin
          // The beat target wins over a simultaneous timeout.
          if (beats == len_q) begin
            state     <= S_DONE;
            cmp_valid <= 1'b1;
            cmp_err   <= (len_q != '0) && !done_seen;
            cmp_beats <= beats;
          end else if (timed_out) begin
            state     <= S_DONE;
            cmp_valid <= 1'b1;
            cmp_err   <= 1'b1;
            cmp_beats <= beats;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command payload selection for the two command cycles.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_drv = mem_addr_q;
    data_drv = {{(WSZ-1){1'b0}}, w_notr_q};
    if (state == S_CMD_RANGE) begin
      addr_drv = io_addr_q;
      data_drv = len_q;
    end
  end

  // The device owns addr whenever rx_interrupt is low; data is ours only
  // during the command, and never while the device strobes a write.
  assign data_oe = is_cmd(state) && !w_notr;
  assign addr    = io_irq  ? addr_drv : {SZ{1'bz}};
  assign data    = data_oe ? data_drv : {WSZ{1'bz}};

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dma_io_cmd.sv
// Scoreboard bench for dma_io_cmd with a behavioural IO device model.
module tb_dma_io_cmd;
  import dma_pkg::*;

  localparam int SZ      = 8;
  localparam int WSZ     = 8;
  localparam int TIMEOUT = 8;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [SZ-1:0]  req_io_addr;
  logic [WSZ-1:0] req_len;
  logic [SZ-1:0]  req_mem_addr;
  logic           req_w_notr;
  logic           io_irq;
  logic           io_done;
  wire  [SZ-1:0]  addr;
  wire  [WSZ-1:0] data;
  logic           w_notr;
  logic           cmp_valid;
  logic           cmp_err;
  logic [WSZ-1:0] cmp_beats;
  logic           busy;

  // Device-side bus drivers.
  logic           dev_oe;
  logic [SZ-1:0]  dev_addr;
  logic [WSZ-1:0] dev_data;
  assign addr = dev_oe ? dev_addr : {SZ{1'bz}};
  assign data = dev_oe ? dev_data : {WSZ{1'bz}};

  dma_io_cmd #(.SZ(SZ), .WSZ(WSZ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_io_addr  (req_io_addr),
    .req_len      (req_len),
    .req_mem_addr (req_mem_addr),
    .req_w_notr   (req_w_notr),
    .io_irq       (io_irq),
    .io_done      (io_done),
    .addr         (addr),
    .data         (data),
    .w_notr       (w_notr),
    .cmp_valid    (cmp_valid),
    .cmp_err      (cmp_err),
    .cmp_beats    (cmp_beats),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       err;
    logic [7:0] beats;
    int         lat_min;
    int         lat_max;
    int         t_acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } beat_t;
  beat_t beat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] a, input logic [7:0] d);
    beat_t b;
    b.a = a;
    b.d = d;
    beat_q.push_back(b);
  endtask

  // ---------------- IO device model ----------------
  typedef enum {D_IDLE, D_CMD2, D_WAIT, D_WRITE} dev_st_t;
  dev_st_t    dst = D_IDLE;
  int         dev_mode = 0;  // 0 normal, 1 never writes, 2 writes but never signals done
  int         dev_n, dev_i;
  logic [7:0] cmd1_addr, cmd1_data, cmd2_addr, cmd2_data;
  int         cmd1_cyc, cmd2_cyc;
  logic       xfer_irq;

  task automatic drive_beat();
    dev_oe   = 1'b1;
    w_notr   = 1'b1;
    dev_addr = cmd2_addr + 8'(dev_i);
    dev_data = 8'h50 + cmd1_addr + 8'(dev_i);
    if (dev_i == dev_n - 1 && dev_mode == 0) io_done = 1'b1;
  endtask

  initial begin
    dev_oe = 1'b0; dev_addr = '0; dev_data = '0; w_notr = 1'b0; io_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dst = D_IDLE; dev_oe = 1'b0; w_notr = 1'b0; io_done = 1'b0;
      end else begin
        case (dst)
          D_IDLE: if (io_irq === 1'b1) begin
            cmd1_addr = addr; cmd1_data = data; cmd1_cyc = cyc;
            io_done = 1'b0;
            dst = D_CMD2;
          end
          D_CMD2: begin
            cmd2_addr = addr; cmd2_data = data; cmd2_cyc = cyc;
            dst = D_WAIT;
          end
          D_WAIT: begin
            xfer_irq = io_irq;
            dev_n = (dev_mode == 1) ? 0 : int'(cmd1_data);
            dev_i = 0;
            if (dev_n == 0) begin
              if (dev_mode == 0) io_done = 1'b1;
              dst = D_IDLE;
            end else begin
              drive_beat();
              dst = D_WRITE;
            end
          end
          D_WRITE: begin
            dev_i++;
            if (dev_i < dev_n) drive_beat();
            else begin
              dev_oe = 1'b0; w_notr = 1'b0; dst = D_IDLE;
            end
          end
          default: dst = D_IDLE;
        endcase
      end
    end
  end

  // ---------------- monitors ----------------
  // Write beats seen on the resolved bus against the expected beat list.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (w_notr === 1'b1) begin
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: addr 0x%0h data 0x%0h", addr, data);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_addr", 32'(addr), 32'(b.a));
          check("beat_data", 32'(data), 32'(b.d));
        end
      end
    end
  end

  // Completion pulses against the scoreboard.
  initial begin
    logic prev_cmp;
    prev_cmp = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cmp) check("cmp_pulse_width", 32'(cmp_valid), 32'd0);
      if (cmp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmp: err %0d beats %0d", cmp_err, cmp_beats);
        end else begin
          exp_t e;
          int lat;
          e = sb.pop_front();
          lat = cyc - e.t_acc;
          check("cmp_err", 32'(cmp_err), 32'(e.err));
          check("cmp_beats", 32'(cmp_beats), 32'(e.beats));
          if (e.lat_min >= 0) begin
            checks++;
            if (lat < e.lat_min || lat > e.lat_max) begin
              failures++;
              $display("FAIL cmp_latency: got %0d expected %0d..%0d", lat, e.lat_min, e.lat_max);
            end
          end
        end
      end
      prev_cmp = (cmp_valid === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [7:0] ia, input logic [7:0] ln, input logic [7:0] ma,
                       input logic wn, input bit push, input logic e_err,
                       input logic [7:0] e_beats, input int lmin, input int lmax,
                       output int t_acc);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_io_addr = ia; req_len = ln; req_mem_addr = ma; req_w_notr = wn;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    t_acc = cyc;
    if (push) begin
      e.err = e_err; e.beats = e_beats; e.lat_min = lmin; e.lat_max = lmax; e.t_acc = t_acc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no completion after %0d cycles", name, n);
      sb.delete();
    end
    @(negedge clk); #2;
  endtask

  task automatic check_cmd(input logic [7:0] ia, input logic [7:0] ln, input logic [7:0] ma,
                           input logic [7:0] d2, input int t_acc);
    check("cmd1_addr", 32'(cmd1_addr), 32'(ia));
    check("cmd1_data", 32'(cmd1_data), 32'(ln));
    check("cmd2_addr", 32'(cmd2_addr), 32'(ma));
    check("cmd2_data", 32'(cmd2_data), 32'(d2));
    check("cmd1_cycle", 32'(cmd1_cyc - t_acc), 32'd1);
    check("cmd2_cycle", 32'(cmd2_cyc - t_acc), 32'd2);
    check("irq_low_in_xfer", 32'(xfer_irq), 32'd0);
  endtask

  initial begin
    int t;
    int n;
    rst = 1'b0; req_valid = 1'b0; req_io_addr = '0; req_len = '0;
    req_mem_addr = '0; req_w_notr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_io_irq", 32'(io_irq), 32'd0);
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("rst_cmp_err", 32'(cmp_err), 32'd0);
    check("rst_cmp_beats", 32'(cmp_beats), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    // Basic read: 4 beats from IO index 3 into memory 0x20
    dev_mode = 0;
    push_beat(8'h20, 8'h53); push_beat(8'h21, 8'h54);
    push_beat(8'h22, 8'h55); push_beat(8'h23, 8'h56);
    issue(8'h03, 8'd4, 8'h20, 1'b1, 1'b1, 1'b0, 8'd4, -1, -1, t);
    wait_done("basic");
    check_cmd(8'h03, 8'd4, 8'h20, 8'h01, t);
    check("basic_beats_left", 32'(beat_q.size()), 32'd0);

    // Zero length: completes CMD_CYCLES + 2 cycles after the accept cycle
    issue(8'h05, 8'd0, 8'h40, 1'b0, 1'b1, 1'b0, 8'd0, CMD_CYCLES + 2, CMD_CYCLES + 2, t);
    wait_done("zero_len");
    check_cmd(8'h05, 8'd0, 8'h40, 8'h00, t);

    // Timeout: device never writes
    dev_mode = 1;
    issue(8'h01, 8'd2, 8'h60, 1'b1, 1'b1, 1'b1, 8'd0, 11, 12, t);
    wait_done("timeout");
    check_cmd(8'h01, 8'd2, 8'h60, 8'h01, t);

    // Missing done: three beats but the done flag never rises
    dev_mode = 2;
    push_beat(8'h80, 8'h60); push_beat(8'h81, 8'h61); push_beat(8'h82, 8'h62);
    issue(8'h10, 8'd3, 8'h80, 1'b1, 1'b1, 1'b1, 8'd3, -1, -1, t);
    wait_done("no_done");
    check("no_done_beats_left", 32'(beat_q.size()), 32'd0);

    // Reset during the second beat of a 4-beat transfer
    dev_mode = 0;
    push_beat(8'h30, 8'h50); push_beat(8'h31, 8'h51);
    issue(8'h00, 8'd4, 8'h30, 1'b0, 1'b0, 1'b0, 8'd0, -1, -1, t);
    n = 0;
    while (!(w_notr === 1'b1 && dev_i == 1) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL midrst_wait: second beat not seen after %0d cycles", n);
    end
    #1 rst = 1'b0;
    #1;
    check("midrst_io_irq", 32'(io_irq), 32'd0);
    check("midrst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("midrst_cmp_err", 32'(cmp_err), 32'd0);
    check("midrst_cmp_beats", 32'(cmp_beats), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr_bus", 32'(addr), 32'h31);
    check("midrst_data_bus", 32'(data), 32'h51);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    check("midrst_beats_left", 32'(beat_q.size()), 32'd0);

    // Clean one-beat transfer after reset, with a request arriving while busy
    push_beat(8'h90, 8'h57);
    issue(8'h07, 8'd1, 8'h90, 1'b1, 1'b1, 1'b0, 8'd1, -1, -1, t);
    req_valid = 1'b1; req_io_addr = 8'hEE; req_len = 8'd9; req_mem_addr = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("busy_req_ready", 32'(req_ready), 32'd0);
      check("busy_flag", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_done("post_rst");
    check_cmd(8'h07, 8'd1, 8'h90, 8'h01, t);
    check("post_rst_beats_left", 32'(beat_q.size()), 32'd0);

    // Let any spurious completion from the ignored request surface
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dma_io_cmd.md
Name: dma_io_cmd

Overview:
Initiator side of the DMA-to-IO command protocol. It takes a transfer request from the DMA controller and issues the two-cycle command sequence to an IO device: rx_interrupt high, with addr/data carrying the command. It then releases the shared bus and monitors the IO device's writes into memory. Completion, or an error, is reported back to the controller as a one-cycle pulse.

Parameters:
SZ, 8, address bus width and IO source address / memory address width
WSZ, 8, data bus width; also the width of the length field (length sent on data)
TIMEOUT, 64, max idle cycles in XFER with no observed write beat before error abort

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous active-low reset
req_valid  input  1  controller presents a transfer request
req_ready  output  1  high in IDLE; request accepted on the posedge where req_valid && req_ready
req_io_addr  input  SZ  first IO-internal source index
req_len  input  WSZ  beat count, 0 allowed
req_mem_addr  input  SZ  first memory destination address
req_w_notr  input  1  direction bit, sent on data[0] in the second command cycle
io_irq  output  1  drives the IO device's rx_interrupt
io_done  input  1  IO device's tx_interrupt (level, sticky in the device)
addr  inout  SZ  shared address bus
data  inout  WSZ  shared data bus
w_notr  input  1  IO device's bus write strobe (observed only)
cmp_valid  output  1  one-cycle completion pulse
cmp_err  output  1  valid with cmp_valid: timeout or done-flag mismatch
cmp_beats  output  WSZ  valid with cmp_valid: number of write beats observed
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE; io_irq=0, cmp_valid=0, cmp_err=0, cmp_beats=0, busy=0; addr/data released ('z) immediately, also mid-transfer.
- States: IDLE, CMD_RANGE, CMD_DEST, XFER, DONE.
- IDLE: req_ready=1. On accept, latch all req_* fields and go to CMD_RANGE. io_irq becomes 1 in the same posedge (registered).
- CMD_RANGE (1 cycle): io_irq=1, addr=latched io_addr, data=latched len. Next state CMD_DEST.
- CMD_DEST (1 cycle): io_irq=1, addr=latched mem_addr, data={WSZ-1 zeros, w_notr}. Next state XFER; io_irq drops to 0 at that posedge.
- Bus ownership:
  - Drive addr only while io_irq=1, otherwise 'z; the IO device owns addr whenever its rx_interrupt is low.
  - Drive data only in CMD_RANGE/CMD_DEST, otherwise 'z.
  - Never drive data while the w_notr input is high.
- XFER:
  - Each posedge with w_notr=1 increments the beat counter (WSZ bits) and clears the idle counter; otherwise the idle counter increments.
  - Exit to DONE when beats == len, evaluated on registered values. For len=0 this is immediate: XFER lasts exactly 1 cycle.
  - Exit to DONE with err=1 when the idle counter reaches TIMEOUT.
  - Beats beyond len are impossible by construction; the first exit wins.
- io_done check: record io_done rising edge or high level at any point in XFER. At exit:
  - len>0 and io_done never seen → err=1.
  - len=0 → io_done ignored.
- DONE (1 cycle): cmp_valid=1, cmp_err and cmp_beats held valid this cycle only; next state IDLE. cmp_valid is 0 in all other states.
- Latency: accept at T → io_irq high T+1..T+2 → earliest cmp_valid at T+4 (len=0); otherwise last beat +1 cycle.
- req_valid during busy: ignored (req_ready=0); no queuing.
- Width rules: counters wrap-free since len ≤ 2^WSZ-1; the IO device truncates the length to SZ, so the controller keeps len < 2^SZ.

Decomposition:
- dma_pkg: state enum typedef (IDLE, CMD_RANGE, CMD_DEST, XFER, DONE), command-cycle count constant (2), default widths.
- One natural sub-module, dma_beat_mon: beat counter, idle/timeout counter, io_done tracker. Inputs clear/enable/w_notr/io_done; outputs beats, timed_out, done_seen.
- FSM and bus drive stay in dma_io_cmd.

Test Plan:
- Basic read: io_addr=3, len=4, mem_addr=0x20, w_notr=1 with the IO device model → device logs read[3..6]; 4 beats at mem 0x20..0x23; cmp_valid once, cmp_err=0, cmp_beats=4.
- Command timing: accept at cycle T → addr=3/data=4 sampled at T+2 posedge, addr=0x20/data=0x01 at T+3; addr 'z from T+3 onward, data 'z in all XFER cycles.
- Zero length: len=0 → two command cycles, no w_notr, cmp_valid 4 cycles after accept, cmp_beats=0, cmp_err=0.
- Timeout: stub device never asserts w_notr, len=2, TIMEOUT=8 → cmp_valid with cmp_err=1, cmp_beats=0 after 8 idle XFER cycles.
- Missing done: stub asserts w_notr 3 times, io_done held 0, len=3 → cmp_err=1, cmp_beats=3.
- Mid-transfer reset: rst low during the 2nd beat → outputs zero and bus 'z same cycle; after release, a new request len=1 completes cleanly; back-to-back req_valid while busy is not accepted.
